updown_timer_n: RTL

Parametrised WIDTH-bit up/down counter/timer with parallel load, run/stop control, free-run or one-shot mode, and a registered terminal-count pulse. Successor to the fixed 4-bit combinational decrementer: the step arithmetic is still a ripple full-adder chain, now generalised in width and direction and wrapped in registered state and control. It is used as the general event counter and interval timer in the datapath.

---
 rtl/udt_pkg.sv | 15 +
 rtl/updown_timer_n_if.sv | 26 ++
 rtl/addsub_step_n.sv | 23 ++
 rtl/updown_timer_n.sv | 95 +++++++++
 4 files changed

// File: rtl/udt_pkg.sv
// Shared definitions for updown_timer_n: state encoding and dir/mode constants.
package udt_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'b00,
        RUN  = 2'b01,
        DONE = 2'b10
    } udt_state_e;

    localparam logic DIR_UP       = 1'b1;
    localparam logic DIR_DOWN     = 1'b0;
    localparam logic MODE_FREE    = 1'b0;
    localparam logic MODE_ONESHOT = 1'b1;

endpackage

// File: rtl/updown_timer_n_if.sv
// Control/status bundle of updown_timer_n; master drives controls, slave is the timer.
interface updown_timer_n_if #(
    parameter int unsigned WIDTH = 8
);
    logic             load;
    logic [WIDTH-1:0] load_val;
    logic             start;
    logic             stop;
    logic             en;
    logic             dir;
    logic             mode;
    logic [WIDTH-1:0] count;
    logic             tc;
    logic             busy;
    logic             done;

    modport master (
        output load, load_val, start, stop, en, dir, mode,
        input  count, tc, busy, done
    );

    modport slave (
        input  load, load_val, start, stop, en, dir, mode,
        output count, tc, busy, done
    );
endinterface

// File: rtl/addsub_step_n.sv
// Combinational +/-1 as a ripple full-adder chain: up adds 0 with carry-in 1,
// down adds all-ones with carry-in 0.
module addsub_step_n #(
    parameter int unsigned WIDTH = 8
) (
    input  logic [WIDTH-1:0] a,
    input  logic             up,
    output logic [WIDTH-1:0] y
);
    logic [WIDTH-1:0] b;

    assign b = up ? '0 : '1;

    always_comb begin : ripple
        logic carry;
        carry = up;
        y     = '0;
        for (int i = 0; i < int'(WIDTH); i++) begin
            y[i]  = a[i] ^ b[i] ^ carry;
            carry = (a[i] & b[i]) | (carry & (a[i] ^ b[i]));
        end
    end
endmodule

// File: rtl/updown_timer_n.sv
// Up/down counter/timer with load, run/stop, free-run or one-shot and registered tc.
// Optional UDT_RELOAD_EN adds a reload register for programmable free-run periods.
module updown_timer_n
    import udt_pkg::*;
#(
    parameter int unsigned WIDTH = 8
) (
    input logic              clk,
    input logic              rst,
    updown_timer_n_if.slave  bus
);
    udt_state_e       state_q, state_d;
    logic [WIDTH-1:0] count_q, count_d;
    logic             tc_q, tc_d;
    logic [WIDTH-1:0] step_val, next_val, term;
`ifdef UDT_RELOAD_EN
    logic [WIDTH-1:0] reload_q, reload_d;
`endif

    addsub_step_n #(
        .WIDTH(WIDTH)
    ) u_step (
        .a  (count_q),
        .up (bus.dir == DIR_UP),
        .y  (step_val)
    );

    assign term = (bus.dir == DIR_UP) ? '1 : '0;

    always_comb begin
        next_val = step_val;
`ifdef UDT_RELOAD_EN
        // Free-run leaves terminal via the reload value instead of wrapping.
        if (bus.mode == MODE_FREE && count_q == term) next_val = reload_q;
`endif
    end

    always_comb begin
        state_d = state_q;
        count_d = count_q;
        tc_d    = 1'b0;
`ifdef UDT_RELOAD_EN
        reload_d = reload_q;
`endif
        if (bus.load) begin
            count_d = bus.load_val;
            state_d = IDLE;
`ifdef UDT_RELOAD_EN
            reload_d = bus.load_val;
`endif
        end else if (bus.stop) begin
            if (state_q == RUN) state_d = IDLE;
        end else if (bus.start && state_q != RUN) begin
            state_d = RUN;
`ifdef UDT_RELOAD_EN
            if (state_q == DONE) count_d = reload_q;
`endif
        end else if (state_q == RUN && bus.en) begin
            if (bus.mode == MODE_ONESHOT && count_q == term) begin
                // Started already at terminal: finish without stepping.
                state_d = DONE;
                tc_d    = 1'b1;
            end else begin
                count_d = next_val;
                if (next_val == term) begin
                    tc_d = 1'b1;
                    if (bus.mode == MODE_ONESHOT) state_d = DONE;
                end
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q  <= IDLE;
            count_q  <= '0;
            tc_q     <= 1'b0;
`ifdef UDT_RELOAD_EN
            reload_q <= '0;
`endif
        end else begin
            state_q  <= state_d;
            count_q  <= count_d;
            tc_q     <= tc_d;
`ifdef UDT_RELOAD_EN
            reload_q <= reload_d;
`endif
        end
    end

    assign bus.count = count_q;
    assign bus.tc    = tc_q;
    assign bus.busy  = (state_q == RUN);
    assign bus.done  = (state_q == DONE);
endmodule
